keypad_code_entry: RTL
======================

Name: keypad_code_entry

Overview:
- Front-end feeding the lock FSM: collects decoded keypad presses into a fixed-length PIN and hands it to the lock over a valid/ready handshake.
- It is the sending end of the code interface the lock FSM consumes.
- It supplies digit progress while the lock is in INPUT and a complete code when the lock enters VERIFY.
- Contains its own 3-state FSM, digit shift buffer, digit counter and inactivity timer.

Parameters:
- DIGITS, 4: number of BCD digits in a code.
- TIMEOUT, 1000: idle clock cycles allowed between keys during entry before the partial code is discarded.
- CNT_W, $clog2(DIGITS+1): width of digit_count.
- TMR_W, $clog2(TIMEOUT): width of the inactivity timer.

Ports:
- clk, input, 1: single system clock; all state updates on the rising edge.
- reset, input, 1: asynchronous, active-low (0 = reset asserted); clears all state immediately, independent of clk.
- key_valid, input, 1: one-cycle strobe; a key is present on key_code.
- key_code, input, 4: 0x0-0x9 digit, 0xA CLEAR, 0xB ENTER, 0xC-0xF reserved.
- code_ready, input, 1: lock FSM accepts the code.
- code, output, 4*DIGITS: assembled code; first digit in the most significant nibble.
- code_valid, output, 1: code is presented.
- digit_count, output, CNT_W: digits currently held.
- entry_error, output, 1: one-cycle pulse on a rejected entry.
- busy, output, 1: high in SEND.

Behaviour:
- Reset values: code=0, code_valid=0, digit_count=0, entry_error=0, busy=0, buffer=0, timer=0, state=IDLE.
- All outputs are registered.
- States are IDLE=2'b00, COLLECT=2'b01, SEND=2'b10. The unused encoding 2'b11 goes to IDLE on the next edge.
- Reserved key codes 0xC-0xF are ignored in every state, with no error and no timer reload.
- IDLE state:
  - Digit d: buffer={buffer[4*DIGITS-5:0],d}, digit_count=1, go to COLLECT.
  - ENTER: entry_error pulse; stay in IDLE.
  - CLEAR: no effect.
- COLLECT state:
  - Digit with digit_count<DIGITS: shift in d, digit_count+1.
  - Digit with digit_count==DIGITS: digit is dropped; entry_error pulse; buffer and count unchanged.
  - CLEAR: buffer=0, digit_count=0, go to IDLE; no error.
  - ENTER with digit_count==DIGITS: go to SEND.
  - ENTER with digit_count<DIGITS: entry_error pulse, buffer=0, digit_count=0, go to IDLE.
  - Timer: reloads to 0 on every accepted key and increments on every other COLLECT cycle.
  - Timeout: when the timer equals TIMEOUT-1 and no key arrives that cycle, the next edge gives buffer=0, digit_count=0, IDLE and an entry_error pulse.
  - Key and expiry in the same cycle: the key wins; it is processed normally and the timer reloads.
- SEND state:
  - code=buffer, code_valid=1, busy=1. code is held stable until transfer.
  - Transfer occurs on an edge where code_valid and code_ready are both 1. The next cycle gives code_valid=0, code=0, buffer=0, digit_count=0, IDLE.
  - key_valid in SEND is ignored entirely: no error and no buffer change.
  - The timer does not run in SEND.
  - code_ready while code_valid=0 has no effect.
- Latency:
  - A key strobe sampled at edge N is reflected in digit_count/state after edge N.
  - ENTER sampled at edge N gives code_valid=1 after edge N.
  - entry_error is high for exactly the cycle after the offending edge.
- code is 0 whenever code_valid=0.
- reset asserted at any point, including mid-SEND with code_valid high, forces all reset values immediately; no handshake completes.
- Deassertion of reset is taken as synchronised externally.

Test Plan:
- Power-up: hold reset=0 for 3 cycles, then release -> all outputs 0, state IDLE; a key_valid with 0xF for 1 cycle -> no output change.
- Happy path (DIGITS=4): keys 1,2,3,4, ENTER, with code_ready=0 for 5 cycles -> digit_count steps 1,2,3,4; code_valid=1 and code=16'h1234 stable for all 5 cycles.
  - Then code_ready=1 for 1 cycle -> code_valid=0, code=0, digit_count=0 on the next cycle.
- Short code: keys 5,6, ENTER -> entry_error high for 1 cycle; digit_count=0; code_valid never rises.
- Overflow: keys 9,8,7,6,5 -> entry_error pulse on the 5th key, digit_count stays 4; then ENTER -> code=16'h9876.
- Timeout (TIMEOUT=16): key 7, then no keys -> after 16 idle cycles digit_count=0 with an entry_error pulse.
  - Repeat with a key 3 on the expiry cycle -> digit_count=2, no error.
- Abort/reset: keys 1,2, CLEAR -> digit_count=0, no error.
  - Reach SEND with code_valid=1, then drive reset=0 mid-cycle -> code_valid drops without a clock edge.
  - key_valid during SEND -> ignored, busy=1.

Source files
------------

// File: rtl/keypad_code_entry_if.sv
// Code hand-off channel from the keypad front-end to the lock FSM.
// The master presents code/code_valid; the slave answers with code_ready.
interface keypad_code_entry_if #(
  parameter int DIGITS = 4
);
  logic [4*DIGITS-1:0] code;
  logic                code_valid;
  logic                code_ready;

  modport master (output code, output code_valid, input  code_ready);
  modport slave  (input  code, input  code_valid, output code_ready);
endinterface

// File: rtl/keypad_code_entry.sv
// Keypad front-end: collects BCD digits into a fixed-length PIN and presents
// it to the lock FSM over a valid/ready handshake, with an inactivity timeout.
module keypad_code_entry #(
  parameter int DIGITS  = 4,
  parameter int TIMEOUT = 1000,
  parameter int CNT_W   = $clog2(DIGITS+1),
  parameter int TMR_W   = $clog2(TIMEOUT)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 key_valid,
  input  logic [3:0]           key_code,
  keypad_code_entry_if.master  cif,
  output logic [CNT_W-1:0]     digit_count,
  output logic                 entry_error,
  output logic                 busy
);
  localparam int CW = 4*DIGITS;

  typedef enum logic [1:0] {IDLE = 2'b00, COLLECT = 2'b01, SEND = 2'b10} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    shreg_q, shreg_d, code_q, code_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             valid_q, valid_d, err_q, err_d, busy_q, busy_d;

  // Reserved codes 0xC-0xF fall out of every decode and are invisible.
  logic is_digit, is_clr, is_ent, any_key, full, expired, xfer;
  assign is_digit = key_valid && (key_code <= 4'd9);
  assign is_clr   = key_valid && (key_code == 4'hA);
  assign is_ent   = key_valid && (key_code == 4'hB);
  assign any_key  = is_digit || is_clr || is_ent;
  assign full     = (cnt_q == CNT_W'(DIGITS));
  assign expired  = (tmr_q == TMR_W'(TIMEOUT-1));
  assign xfer     = valid_q && cif.code_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      code_q  <= '0;
      cnt_q   <= '0;
      tmr_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (is_digit) state_d = COLLECT;
      COLLECT: begin
        if (is_clr)                    state_d = IDLE;
        else if (is_ent)               state_d = full ? SEND : IDLE;
        else if (!any_key && expired)  state_d = IDLE;
      end
      SEND:    if (xfer) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    shreg_d = shreg_q;
    code_d  = code_q;
    cnt_d   = cnt_q;
    tmr_d   = '0;
    valid_d = valid_q;
    err_d   = 1'b0;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        code_d  = '0;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        if (is_digit) begin
          shreg_d = {shreg_q[CW-5:0], key_code};
          cnt_d   = CNT_W'(1);
        end else if (is_ent) begin
          err_d = 1'b1;
        end
      end
      COLLECT: begin
        // Any real key restarts the idle window, even one that gets rejected.
        tmr_d = any_key ? '0 : tmr_q + TMR_W'(1);
        if (is_digit) begin
          if (full) err_d = 1'b1;
          else begin
            shreg_d = {shreg_q[CW-5:0], key_code};
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end else if (is_clr) begin
          shreg_d = '0;
          cnt_d   = '0;
        end else if (is_ent) begin
          if (full) begin
            code_d  = shreg_q;
            valid_d = 1'b1;
            busy_d  = 1'b1;
          end else begin
            err_d   = 1'b1;
            shreg_d = '0;
            cnt_d   = '0;
          end
        end else if (expired) begin
          err_d   = 1'b1;
          shreg_d = '0;
          cnt_d   = '0;
          tmr_d   = '0;
        end
      end
      SEND: begin
        if (xfer) begin
          code_d  = '0;
          valid_d = 1'b0;
          busy_d  = 1'b0;
          shreg_d = '0;
          cnt_d   = '0;
        end else begin
          busy_d = 1'b1;
        end
      end
      default: begin
        code_d  = '0;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign cif.code       = code_q;
  assign cif.code_valid = valid_q;
  assign digit_count    = cnt_q;
  assign entry_error    = err_q;
  assign busy           = busy_q;
endmodule
